// File: rtl/dram_l2_pkg.sv
// Shared constants for the DRAM/L2 repeater buffer: return sideband bit
// positions, request address field bounds and legal parameter ranges.
package dram_l2_pkg;

  localparam int RSB_RD_ACK       = 9;
  localparam int RSB_WR_ACK       = 8;
  localparam int RSB_CHUNK_MSB    = 7;
  localparam int RSB_CHUNK_LSB    = 6;
  localparam int RSB_REQ_ID_MSB   = 5;
  localparam int RSB_REQ_ID_LSB   = 3;
  localparam int RSB_SECC_ERR     = 2;
  localparam int RSB_MECC_ERR     = 1;
  localparam int RSB_SCB_MECC_ERR = 0;

  // Physical address bits carried in the request (line-aligned, 32B lines)
  localparam int REQ_ADDR_LSB = 5;
  localparam int REQ_ADDR_MSB = 39;
  localparam int REQ_ADDR_W   = REQ_ADDR_MSB - REQ_ADDR_LSB + 1;

  localparam int STAGES_MIN    = 1;
  localparam int STAGES_MAX    = 4;
  localparam int REQ_DEPTH_MIN = 2;
  localparam int REQ_DEPTH_MAX = 16;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/dram_l2_req_fifo.sv
// Request-channel decoupling FIFO: circular buffer with extra-MSB pointers,
// no fall-through, and a sticky overflow flag for pushes attempted while full.
module dram_l2_req_fifo #(
  parameter int REQ_W     = 105,
  parameter int REQ_DEPTH = 4,
  localparam int PTR_W    = $clog2(REQ_DEPTH) + 1
) (
  input  logic             rclk,
  input  logic             arst_l,
  input  logic             req_vld_in,
  output logic             req_rdy_out,
  input  logic [REQ_W-1:0] req_data_in,
  output logic             req_vld_out,
  input  logic             req_rdy_in,
  output logic [REQ_W-1:0] req_data_out,
  output logic [PTR_W-1:0] req_cnt,
  output logic             req_ovf
);

  localparam int AW = PTR_W - 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [REQ_W-1:0] mem [REQ_DEPTH];
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Flags depend only on pointer registers, never on the handshake inputs
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign req_rdy_out  = !full;
  assign req_vld_out  = !empty;
  assign req_cnt      = wr_ptr - rd_ptr;
  assign req_data_out = mem[rd_ptr[AW-1:0]];

  assign push = req_vld_in && !full;
  assign pop  = !empty && req_rdy_in;

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      req_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (req_vld_in && full) req_ovf <= 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define what is valid
  always_ff @(posedge rclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= req_data_in;
  end

endmodule

// File: rtl/dram_l2_rpt_buf.sv
// Registered DRAM/L2 channel repeater: STAGES-deep return retiming chain with
// valid-qualified data/ECC loads, plus a FIFO-decoupled request channel.
module dram_l2_rpt_buf
  import dram_l2_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int ECC_W     = 28,
  parameter int RSB_W     = 10,
  parameter int STAGES    = 2,
  parameter int REQ_W     = 105,
  parameter int REQ_DEPTH = 4
) (
  input  logic                         rclk,
  input  logic                         arst_l,
  input  logic                         ret_vld_in,
  input  logic [DATA_W-1:0]            ret_data_in,
  input  logic [ECC_W-1:0]             ret_ecc_in,
  input  logic [RSB_W-1:0]             ret_sb_in,
  output logic                         ret_vld_out,
  output logic [DATA_W-1:0]            ret_data_out,
  output logic [ECC_W-1:0]             ret_ecc_out,
  output logic [RSB_W-1:0]             ret_sb_out,
  input  logic                         req_vld_in,
  output logic                         req_rdy_out,
  input  logic [REQ_W-1:0]             req_data_in,
  output logic                         req_vld_out,
  input  logic                         req_rdy_in,
  output logic [REQ_W-1:0]             req_data_out,
  output logic [$clog2(REQ_DEPTH):0]   req_cnt,
  output logic                         req_ovf
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("dram_l2_rpt_buf: STAGES=%0d outside %0d..%0d", STAGES, STAGES_MIN, STAGES_MAX);
  end
  if (!is_pow2(REQ_DEPTH) || REQ_DEPTH < REQ_DEPTH_MIN || REQ_DEPTH > REQ_DEPTH_MAX) begin : g_bad_depth
    $error("dram_l2_rpt_buf: REQ_DEPTH=%0d must be a power of two in %0d..%0d",
           REQ_DEPTH, REQ_DEPTH_MIN, REQ_DEPTH_MAX);
  end

  logic              vld_p  [STAGES+1];
  logic [DATA_W-1:0] data_p [STAGES+1];
  logic [ECC_W-1:0]  ecc_p  [STAGES+1];
  logic [RSB_W-1:0]  sb_p   [STAGES+1];

  assign vld_p[0]  = ret_vld_in;
  assign data_p[0] = ret_data_in;
  assign ecc_p[0]  = ret_ecc_in;
  assign sb_p[0]   = ret_sb_in;

  for (genvar i = 0; i < STAGES; i++) begin : g_ret_stage
    logic              vld_q;
    logic [DATA_W-1:0] data_q;
    logic [ECC_W-1:0]  ecc_q;
    logic [RSB_W-1:0]  sb_q;

    // --- return stage boundary i -> i+1 ---
    // Sideband is free-running: ack/err pulses may arrive without a data beat
    always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
        vld_q  <= 1'b0;
        sb_q   <= '0;
        data_q <= '0;
        ecc_q  <= '0;
      end else begin
        vld_q <= vld_p[i];
        sb_q  <= sb_p[i];
        if (vld_p[i]) begin
          data_q <= data_p[i];
          ecc_q  <= ecc_p[i];
        end
      end
    end

    assign vld_p[i+1]  = vld_q;
    assign data_p[i+1] = data_q;
    assign ecc_p[i+1]  = ecc_q;
    assign sb_p[i+1]   = sb_q;
  end

  assign ret_vld_out  = vld_p[STAGES];
  assign ret_data_out = data_p[STAGES];
  assign ret_ecc_out  = ecc_p[STAGES];
  assign ret_sb_out   = sb_p[STAGES];

  dram_l2_req_fifo #(
    .REQ_W     (REQ_W),
    .REQ_DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .rclk         (rclk),
    .arst_l       (arst_l),
    .req_vld_in   (req_vld_in),
    .req_rdy_out  (req_rdy_out),
    .req_data_in  (req_data_in),
    .req_vld_out  (req_vld_out),
    .req_rdy_in   (req_rdy_in),
    .req_data_out (req_data_out),
    .req_cnt      (req_cnt),
    .req_ovf      (req_ovf)
  );

endmodule

// File: tb/tb_dram_l2_rpt_buf.sv
// Directed scoreboard bench for dram_l2_rpt_buf with STAGES=3, REQ_DEPTH=4.
module tb_dram_l2_rpt_buf;
  import dram_l2_pkg::*;

  localparam int DATA_W    = 128;
  localparam int ECC_W     = 28;
  localparam int RSB_W     = 10;
  localparam int STAGES    = 3;
  localparam int REQ_W     = 105;
  localparam int REQ_DEPTH = 4;

  logic              rclk = 1'b0;
  logic              arst_l = 1'b1;
  logic              ret_vld_in = 1'b0;
  logic [DATA_W-1:0] ret_data_in = '0;
  logic [ECC_W-1:0]  ret_ecc_in = '0;
  logic [RSB_W-1:0]  ret_sb_in = '0;
  logic              ret_vld_out;
  logic [DATA_W-1:0] ret_data_out;
  logic [ECC_W-1:0]  ret_ecc_out;
  logic [RSB_W-1:0]  ret_sb_out;
  logic              req_vld_in = 1'b0;
  logic              req_rdy_out;
  logic [REQ_W-1:0]  req_data_in = '0;
  logic              req_vld_out;
  logic              req_rdy_in = 1'b0;
  logic [REQ_W-1:0]  req_data_out;
  logic [$clog2(REQ_DEPTH):0] req_cnt;
  logic              req_ovf;

  dram_l2_rpt_buf #(
    .DATA_W(DATA_W), .ECC_W(ECC_W), .RSB_W(RSB_W),
    .STAGES(STAGES), .REQ_W(REQ_W), .REQ_DEPTH(REQ_DEPTH)
  ) dut (
    .rclk(rclk), .arst_l(arst_l),
    .ret_vld_in(ret_vld_in), .ret_data_in(ret_data_in), .ret_ecc_in(ret_ecc_in), .ret_sb_in(ret_sb_in),
    .ret_vld_out(ret_vld_out), .ret_data_out(ret_data_out), .ret_ecc_out(ret_ecc_out), .ret_sb_out(ret_sb_out),
    .req_vld_in(req_vld_in), .req_rdy_out(req_rdy_out), .req_data_in(req_data_in),
    .req_vld_out(req_vld_out), .req_rdy_in(req_rdy_in), .req_data_out(req_data_out),
    .req_cnt(req_cnt), .req_ovf(req_ovf)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic              vld;
    logic [DATA_W-1:0] d;
    logic [ECC_W-1:0]  e;
    logic [RSB_W-1:0]  sb;
  } ret_t;

  ret_t              ret_q[$];
  logic [REQ_W-1:0]  req_q[$];
  logic [DATA_W-1:0] last_d;
  logic [ECC_W-1:0]  last_e;
  logic              exp_ovf;
  int                checks = 0;
  int                errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ret_t z;
    z.vld = 1'b0; z.d = '0; z.e = '0; z.sb = '0;
    ret_q.delete();
    for (int i = 0; i < STAGES - 1; i++) ret_q.push_back(z);
    req_q.delete();
    last_d  = '0;
    last_e  = '0;
    exp_ovf = 1'b0;
  endtask

  // Asserts reset away from the clock edge and checks outputs clear at once
  task automatic reset_now();
    arst_l = 1'b0;
    #1;
    chk("rst_ret_vld", 128'(ret_vld_out), 128'(0));
    chk("rst_ret_data", 128'(ret_data_out), 128'(0));
    chk("rst_ret_sb", 128'(ret_sb_out), 128'(0));
    chk("rst_req_vld", 128'(req_vld_out), 128'(0));
    chk("rst_req_cnt", 128'(req_cnt), 128'(0));
    chk("rst_req_rdy", 128'(req_rdy_out), 128'(1));
    chk("rst_req_ovf", 128'(req_ovf), 128'(0));
    model_reset();
    @(posedge rclk);
    @(posedge rclk);
    #1;
    arst_l = 1'b1;
  endtask

  task automatic cycle();
    ret_t             r;
    bit               push;
    bit               pop;
    logic [REQ_W-1:0] pl;
    r.vld = ret_vld_in; r.d = ret_data_in; r.e = ret_ecc_in; r.sb = ret_sb_in;
    ret_q.push_back(r);
    push = req_vld_in && (req_q.size() < REQ_DEPTH);
    pop  = req_rdy_in && (req_q.size() > 0);
    if (req_vld_in && req_q.size() == REQ_DEPTH) exp_ovf = 1'b1;
    pl = req_data_in;
    @(posedge rclk);
    #1;
    if (pop) void'(req_q.pop_front());
    if (push) req_q.push_back(pl);
    r = ret_q.pop_front();
    if (r.vld) begin
      last_d = r.d;
      last_e = r.e;
    end
    chk("ret_vld", 128'(ret_vld_out), 128'(r.vld));
    chk("ret_sb", 128'(ret_sb_out), 128'(r.sb));
    chk("ret_data", 128'(ret_data_out), 128'(last_d));
    chk("ret_ecc", 128'(ret_ecc_out), 128'(last_e));
    chk("req_cnt", 128'(req_cnt), 128'(req_q.size()));
    chk("req_rdy", 128'(req_rdy_out), 128'(req_q.size() < REQ_DEPTH));
    chk("req_vld", 128'(req_vld_out), 128'(req_q.size() > 0));
    chk("req_ovf", 128'(req_ovf), 128'(exp_ovf));
    if (req_q.size() > 0) chk("req_head", 128'(req_data_out), 128'(req_q[0]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #3;
    reset_now();
    idle(4);

    // Three back-to-back return beats; junk on data while valid is low
    ret_vld_in = 1; ret_data_in = {16{8'hA5}}; ret_ecc_in = 28'hA5A5A5A; ret_sb_in = 10'h101; cycle();
    ret_data_in = {16{8'h5A}}; ret_ecc_in = 28'h5A5A5A5; ret_sb_in = 10'h10A; cycle();
    ret_data_in = {16{8'hFF}}; ret_ecc_in = 28'hFFFFFFF; ret_sb_in = 10'h113; cycle();
    ret_vld_in = 0; ret_data_in = {4{32'hDEADBEEF}}; ret_ecc_in = 28'h1234567; ret_sb_in = '0;
    idle(5);

    // rd_ack pulse without a data beat
    ret_sb_in = 10'(1) << RSB_RD_ACK; cycle();
    ret_sb_in = '0;
    idle(5);

    // Fill with 5 pushes while downstream stalls; the fifth is refused
    req_rdy_in = 0;
    for (int i = 1; i <= 5; i++) begin
      req_vld_in = 1; req_data_in = REQ_W'(i); cycle();
    end
    req_vld_in = 0;
    req_rdy_in = 1;
    idle(5);

    // Simultaneous push/pop at occupancy 2
    req_rdy_in = 0;
    req_vld_in = 1; req_data_in = REQ_W'(10); cycle();
    req_data_in = REQ_W'(11); cycle();
    req_rdy_in = 1; req_data_in = REQ_W'(12); cycle();
    req_data_in = REQ_W'(13); cycle();
    req_vld_in = 0;
    idle(4);

    // Build up cnt=3 with the return pipe full, then reset mid-stream
    req_rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      req_vld_in = 1; req_data_in = {$urandom, $urandom, $urandom, $urandom};
      ret_vld_in = 1; ret_data_in = {$urandom, $urandom, $urandom, $urandom};
      ret_ecc_in = ECC_W'($urandom); ret_sb_in = RSB_W'($urandom);
      cycle();
    end
    req_vld_in = 0; ret_vld_in = 0; ret_sb_in = '0; req_rdy_in = 0;
    reset_now();
    idle(3);

    // 37 push/pop pairs across pointer wrap, plus a return stream alongside
    req_rdy_in = 1;
    for (int i = 0; i < 37; i++) begin
      req_vld_in = 1; req_data_in = {REQ_W'($urandom) << 32, 32'(100 + i)};
      ret_vld_in = i[0]; ret_data_in = {4{32'(i)}}; ret_ecc_in = ECC_W'(i * 3); ret_sb_in = RSB_W'(i);
      cycle();
    end
    req_vld_in = 0; ret_vld_in = 0; ret_sb_in = '0;
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
